// File: rtl/data_memory.sv
// data_memory: word-organised data RAM with byte-lane writes, post-reset zeroing sweep,
// sticky out-of-range flag and saturating write counter, sharing a bidirectional data bus.
module data_memory #(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] dmem_addr,
    inout  wire  [31:0] dmem_data,
    input  logic        dmem_wen,
    input  logic [3:0]  byte_en,
    output logic        ready,
    output logic        addr_err,
    output logic [15:0] wr_count
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {CLEAR, READY} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   clr_idx_q, clr_idx_d;
    logic            addr_err_q, addr_err_d;
    logic [15:0]     wr_count_q, wr_count_d;
    logic [31:0]     mem [DEPTH];
    logic [AW-1:0]   idx;
    logic            in_range;
    logic            wr_en;
    logic [31:0]     rd_data;
    logic            addr_unused;

    // The byte offset never selects anything: whole words are always addressed.
    assign addr_unused = &{1'b0, dmem_addr[1:0]};
    assign idx         = dmem_addr[AW+1:2];
    assign in_range    = ~|dmem_addr[31:AW+2];
    assign wr_en       = ready && dmem_wen && in_range && |byte_en;
    assign rd_data     = in_range ? mem[idx] : 32'h0;
    assign dmem_data   = (ready && !dmem_wen) ? rd_data : 'z;
    assign addr_err    = addr_err_q;
    assign wr_count    = wr_count_q;

    // State register plus sweep index, error flag and write counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= CLEAR;
            clr_idx_q  <= '0;
            addr_err_q <= 1'b0;
            wr_count_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_idx_q  <= clr_idx_d;
            addr_err_q <= addr_err_d;
            wr_count_q <= wr_count_d;
        end
    end

    // Next state: sweep every word once, then stay ready until the next reset.
    always_comb begin
        state_d    = (state_q == CLEAR && clr_idx_q == AW'(DEPTH - 1)) ? READY : state_q;
        clr_idx_d  = (state_q == CLEAR) ? clr_idx_q + AW'(1) : clr_idx_q;
        addr_err_d = addr_err_q | (ready && !in_range);
        wr_count_d = wr_count_q + 16'((wr_en && wr_count_q != 16'hFFFF) ? 1 : 0);
    end

    // Output decode: accesses are accepted only once the sweep has finished.
    always_comb begin
        ready = (state_q == READY);
    end

    // Array has no reset; the sweep zeroes it, after which lane-masked writes apply.
    always_ff @(posedge clk) begin
        if (!ready) begin
            mem[clr_idx_q] <= '0;
        end else if (wr_en) begin
            for (int n = 0; n < 4; n++) begin
                if (byte_en[n]) mem[idx][8*n +: 8] <= dmem_data[8*n +: 8];
            end
        end
    end
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed stimulus against a word-array reference model of data_memory.
module tb_data_memory;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] dmem_addr = '0;
    logic        dmem_wen = 1'b0;
    logic [3:0]  byte_en = '0;
    logic [31:0] tb_wd = '0;
    tri1  [31:0] dmem_data;
    logic        ready;
    logic        addr_err;
    logic [15:0] wr_count;

    int checks = 0;
    int errors = 0;

    // Undriven bus floats to all ones through the pull, so any DUT drive is visible.
    assign dmem_data = dmem_wen ? tb_wd : 'z;

    data_memory #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .dmem_addr(dmem_addr), .dmem_data(dmem_data),
        .dmem_wen(dmem_wen), .byte_en(byte_en), .ready(ready),
        .addr_err(addr_err), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: ready after DEPTH clocks out of reset, then plain word-array semantics.
    logic [31:0] m_mem [DEPTH];
    int          m_cyc;
    logic        m_err;
    logic [15:0] m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc = 0;
            m_err = 1'b0;
            m_cnt = 16'h0;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
        end else if (m_cyc < DEPTH) begin
            m_cyc++;
        end else if ((dmem_addr >> 2) >= DEPTH) begin
            m_err = 1'b1;
        end else if (dmem_wen && byte_en != 4'b0) begin
            for (int n = 0; n < 4; n++)
                if (byte_en[n]) m_mem[dmem_addr >> 2][8*n +: 8] = dmem_data[8*n +: 8];
            if (m_cnt != 16'hFFFF) m_cnt++;
        end
    end

    always @(negedge clk) begin
        logic [31:0] exp_bus;
        chk("ready", {31'b0, ready}, {31'b0, m_cyc >= DEPTH});
        chk("addr_err", {31'b0, addr_err}, {31'b0, m_err});
        chk("wr_count", {16'b0, wr_count}, {16'b0, m_cnt});
        if (!dmem_wen) begin
            if (m_cyc < DEPTH) exp_bus = 32'hFFFF_FFFF;
            else if ((dmem_addr >> 2) >= DEPTH) exp_bus = 32'h0;
            else exp_bus = m_mem[dmem_addr >> 2];
            chk("bus", dmem_data, exp_bus);
        end
    end

    task automatic cyc(input logic [31:0] a, input logic w, input logic [3:0] be, input logic [31:0] d);
        dmem_addr = a;
        dmem_wen  = w;
        byte_en   = be;
        tb_wd     = d;
        @(posedge clk);
        #1;
    endtask

    task automatic rd_lit(input string name, input logic [31:0] a, input logic [31:0] exp);
        dmem_addr = a;
        dmem_wen  = 1'b0;
        byte_en   = 4'b0;
        #2;
        chk(name, dmem_data, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic sweep();
        logic [31:0] tbl [4];
        tbl = '{32'h0, 32'h200, 32'h3FC, 32'h400};
        for (int i = 1; i <= DEPTH; i++) begin
            dmem_addr = tbl[i % 4];
            dmem_wen  = 1'b0;
            #2;
            if (i == 1 || i == 130) chk("lit_bus_z_clear", dmem_data, 32'hFFFF_FFFF);
            @(posedge clk);
            #1;
            if (i == DEPTH - 1) chk("lit_ready_255", {31'b0, ready}, 32'h0);
            if (i == DEPTH) chk("lit_ready_256", {31'b0, ready}, 32'h1);
        end
        chk("lit_err_after_sweep", {31'b0, addr_err}, 32'h0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sweep();
        rd_lit("lit_rd_0", 32'h0, 32'h0);
        rd_lit("lit_rd_200", 32'h200, 32'h0);
        rd_lit("lit_rd_3fc", 32'h3FC, 32'h0);

        cyc(32'h10, 1'b1, 4'b1111, 32'hDEAD_BEEF);
        cyc(32'h11, 1'b1, 4'b0010, 32'h0000_AA00);
        rd_lit("lit_merge", 32'h10, 32'hDEAD_AAEF);
        chk("lit_cnt2", {16'b0, wr_count}, 32'd2);

        cyc(32'h20, 1'b1, 4'b0000, 32'h1234_5678);
        rd_lit("lit_no_lane", 32'h20, 32'h0);
        chk("lit_cnt_be0", {16'b0, wr_count}, 32'd2);
        cyc(32'h20, 1'b1, 4'b1010, 32'h1234_5678);
        rd_lit("lit_lanes_1010", 32'h20, 32'h1200_5600);

        chk("lit_err_pre", {31'b0, addr_err}, 32'h0);
        rd_lit("lit_oor_rd", 32'h400, 32'h0);
        chk("lit_err_set", {31'b0, addr_err}, 32'h1);
        cyc(32'h400, 1'b1, 4'b1111, 32'hFFFF_FFFF);
        rd_lit("lit_oor_no_alias", 32'h0, 32'h0);
        rd_lit("lit_oor_keep10", 32'h10, 32'hDEAD_AAEF);
        chk("lit_cnt_oor", {16'b0, wr_count}, 32'd3);
        chk("lit_err_sticky", {31'b0, addr_err}, 32'h1);

        cyc(32'h8, 1'b1, 4'b1111, 32'hCAFE_F00D);
        rd_lit("lit_rd_8", 32'h8, 32'hCAFE_F00D);
        rst_n = 1'b0;
        #1;
        chk("lit_rst_ready", {31'b0, ready}, 32'h0);
        chk("lit_rst_err", {31'b0, addr_err}, 32'h0);
        chk("lit_rst_cnt", {16'b0, wr_count}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) cyc(32'h8, 1'b1, 4'b1111, 32'hFFFF_FFFF);
        chk("lit_mid_sweep_ready", {31'b0, ready}, 32'h0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sweep();
        rd_lit("lit_rd_8_zero", 32'h8, 32'h0);
        chk("lit_cnt_zero", {16'b0, wr_count}, 32'h0);

        for (int i = 1; i <= 65537; i++) begin
            cyc(32'h4, 1'b1, 4'b1111, 32'(i));
            if (i == 65534) chk("lit_cnt_65534", {16'b0, wr_count}, 32'h0000_FFFE);
            if (i == 65535) chk("lit_cnt_65535", {16'b0, wr_count}, 32'h0000_FFFF);
        end
        chk("lit_cnt_sat", {16'b0, wr_count}, 32'h0000_FFFF);
        rd_lit("lit_last_wr", 32'h4, 32'h0001_0001);
        chk("lit_err_final", {31'b0, addr_err}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Responder side of the CPU data-memory interface: a word-organised RAM with byte-lane writes.
- Drives the shared bidirectional data bus during reads and samples it during writes.
- Sits beside the CPU at top level, connected to the CPU's dmem address, data, write-enable and byte-enable signals.
- Adds a post-reset zeroing sweep (so loads never return X), a sticky out-of-range error flag and a saturating write counter for trace/debug.

Parameters:
DEPTH, 256, number of 32-bit words; power of two, 2..65536.
AW, $clog2(DEPTH), word-index width, derived; not overridable.

Ports:
clk  input  1  clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
dmem_addr  input  32  byte address from CPU; word index = dmem_addr[AW+1:2]
dmem_data  inout  32  shared data bus; CPU drives when dmem_wen=1, this block drives when dmem_wen=0 and ready=1
dmem_wen  input  1  1 = write cycle, 0 = read cycle
byte_en  input  4  write lane enables; bit n covers bits [8n+7:8n]; ignored on reads
ready  output  1  1 = zeroing sweep complete, accesses accepted
addr_err  output  1  sticky; set by any access with dmem_addr[31:2] >= DEPTH
wr_count  output  16  count of accepted writes, saturating

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low on rst_n.
- Reset values (async on rst_n=0):
  - state=CLEAR, clr_idx=0, ready=0, addr_err=0, wr_count=0.
  - dmem_data is high-Z.
  - The memory array has no async reset; the sweep initialises it.
- FSM has two states, CLEAR and READY.
  - CLEAR: each posedge writes mem[clr_idx]=0 and increments clr_idx. At the posedge where clr_idx==DEPTH-1, the last word is zeroed, state goes to READY and ready goes to 1.
  - Sweep latency: ready rises on the DEPTH-th posedge after rst_n deasserts.
  - READY: stays in READY until the next reset.
- Reset mid-sweep or mid-operation: returns to CLEAR with clr_idx=0 and the sweep restarts in full. Partially zeroed contents are irrelevant.
- During CLEAR:
  - dmem_data is high-Z.
  - CPU writes are dropped and are not counted.
  - addr_err is not updated.
- In range: dmem_addr[31:2] < DEPTH. dmem_addr[1:0] selects nothing; the word is always addressed as a whole.
- Read (READY, dmem_wen=0):
  - dmem_data is driven combinationally. In-range value = mem[word index]. Out-of-range value = 32'h0.
  - The value is valid in the same cycle the address is presented (zero-latency read). The CPU extracts bytes/halves itself.
- Write (READY, dmem_wen=1):
  - dmem_data is high-Z (CPU drives it).
  - At posedge, for each n with byte_en[n]=1, mem[idx][8n+7:8n] <= dmem_data[8n+7:8n]. Other lanes are unchanged.
- Accepted write = READY && dmem_wen && in range && byte_en != 0.
  - wr_count increments by 1 on each accepted write and saturates at 16'hFFFF.
  - dmem_wen=1 with byte_en=0: no change, not counted.
- Out-of-range access in READY (read or write) sets addr_err at that posedge. addr_err holds until reset. An out-of-range write leaves memory unchanged.
- Write then read: a read of the same word in the cycle after the write posedge returns the merged data.
- Non-contiguous lanes (e.g. 4'b1010) are legal; lanes are written independently.
- dmem_data bits that are X/Z during a write are stored as-is. No checking is done.
- Bus contention is forbidden: the block never drives while dmem_wen=1 or ready=0.

Test Plan:
1. Release reset with DEPTH=256 -> ready=0 for 255 posedges and 1 after the 256th. Read of byte addresses 0x0, 0x200 and 0x3FC returns 32'h0; dmem_data is Z throughout CLEAR.
2. SW addr 0x10, data 32'hDEADBEEF, byte_en=4'b1111. Then SB addr 0x11, data 32'h0000AA00, byte_en=4'b0010. Then read 0x10 -> 32'hDEADAAEF. wr_count=2.
3. Write with byte_en=4'b0000 to 0x20 (data 32'h12345678) -> read 0x20 returns 32'h0; wr_count unchanged. Write 4'b1010 at 0x20 with data 32'h12345678 -> read returns 32'h12005600.
4. Read 0x400 (word 256, DEPTH=256) -> dmem_data=32'h0 and addr_err=1 after the edge. Write 0x400 -> memory unchanged, not counted; addr_err stays 1 across later legal accesses.
5. Assert rst_n=0 at sweep index 100, release -> ready low for a full 256 cycles again. Assert reset in READY after writing 0x8=32'hCAFEF00D -> after the new sweep, read 0x8 returns 32'h0, wr_count=0, addr_err=0.
6. Force 65537 accepted writes -> wr_count holds 16'hFFFF.
